// File: rtl/queue_drain_tx.sv
// Consumer side of the 8-entry byte queue: pops one byte, waits out the queue's read
// latency, and shifts it out as an async serial frame. Define QUEUE_TX_PARITY_EN for an even-parity bit.
module queue_drain_tx #(
    parameter int BIT_CYCLES = 4,
    parameter int DEQ_LAT    = 3
) (
    input  logic       clock_10KHZ,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] len_in,
    input  logic [7:0] q_data_in,
    output logic       dequeue_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic [7:0] sent_count_out
);

    // One timer serves both the bit period and the dequeue latency wait, so it is sized for the longer.
    localparam int TMAX = (BIT_CYCLES > DEQ_LAT) ? BIT_CYCLES : DEQ_LAT;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] LAT_LAST = TW'(DEQ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        START,
        DATA,
`ifdef QUEUE_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    sent_n;
    logic          tx_n, busy_n, deq_n;
    logic          bit_done;
`ifdef QUEUE_TX_PARITY_EN
    logic          parity, parity_n;
`endif

    assign bit_done = (timer == BIT_LAST);

    // NOTE: every signal assigned below gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        timer_n   = timer + TW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        sent_n    = sent_count_out;
`ifdef QUEUE_TX_PARITY_EN
        parity_n  = parity;
`endif
        case (state)
            IDLE: begin
                timer_n = '0;
                if (enable && len_in != 4'd0)
                    state_n = REQ;
            end
            REQ: begin
                timer_n = '0;
                state_n = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (timer == LAT_LAST) begin
                    timer_n = '0;
                    state_n = START;
                    shreg_n = q_data_in;
`ifdef QUEUE_TX_PARITY_EN
                    parity_n = ^q_data_in;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    timer_n   = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_n = '0;
                    if (bit_idx == 3'd7) begin
`ifdef QUEUE_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end
            end
`ifdef QUEUE_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    timer_n = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    timer_n = '0;
                    sent_n  = sent_count_out + 8'd1;
                    state_n = IDLE;
                end
            end
            default: begin
                timer_n = '0;
                state_n = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with the state they describe.
        deq_n  = (state_n == REQ);
        busy_n = (state_n != IDLE);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef QUEUE_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            timer          <= '0;
            bit_idx        <= 3'd0;
            shreg          <= 8'd0;
            sent_count_out <= 8'd0;
            dequeue_out    <= 1'b0;
            tx_out         <= 1'b1;
            busy_out       <= 1'b0;
`ifdef QUEUE_TX_PARITY_EN
            parity         <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            timer          <= timer_n;
            bit_idx        <= bit_idx_n;
            shreg          <= shreg_n;
            sent_count_out <= sent_n;
            dequeue_out    <= deq_n;
            tx_out         <= tx_n;
            busy_out       <= busy_n;
`ifdef QUEUE_TX_PARITY_EN
            parity         <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_queue_drain_tx.sv
// Directed bench for queue_drain_tx: reset, empty queue, single frame, back-to-back,
// enable drop and mid-frame reset. Honours QUEUE_TX_PARITY_EN for the frame shape.
`timescale 1us/1ns
module tb_queue_drain_tx;

    localparam int BIT_CYCLES = 4;
    localparam int DEQ_LAT    = 3;
`ifdef QUEUE_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clock_10KHZ = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] len_in = 4'd0;
    logic [7:0] q_data_in = 8'd0;
    logic       dequeue_out, tx_out, busy_out;
    logic [7:0] sent_count_out;

    int total = 0;
    int bad = 0;
    int deq_pulses = 0;

    queue_drain_tx #(.BIT_CYCLES(BIT_CYCLES), .DEQ_LAT(DEQ_LAT)) dut (
        .clock_10KHZ   (clock_10KHZ),
        .reset         (reset),
        .enable        (enable),
        .len_in        (len_in),
        .q_data_in     (q_data_in),
        .dequeue_out   (dequeue_out),
        .tx_out        (tx_out),
        .busy_out      (busy_out),
        .sent_count_out(sent_count_out)
    );

    always #50 clock_10KHZ = ~clock_10KHZ;

    always @(negedge clock_10KHZ)
        if (dequeue_out === 1'b1) deq_pulses++;

    // Line levels per bit slot: start, data LSB first, optional even parity, stop.
    function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
`ifdef QUEUE_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic apply_reset();
        enable = 1'b0;
        len_in = 4'd0;
        @(negedge clock_10KHZ);
        reset = 1'b0;
        repeat (2) @(negedge clock_10KHZ);
        reset = 1'b1;
    endtask

    // Returns negedges advanced until tx_out is first seen low, or -1 if the bound runs out.
    task automatic wait_start(input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clock_10KHZ);
            if (tx_out === 1'b0) begin
                waited = i;
                break;
            end
        end
    endtask

    // Called at the first START sample; records each slot's level and whether it held for the whole slot.
    task automatic capture_frame(input int drop_pos, output logic [FB-1:0] bits, output logic stable);
        stable = 1'b1;
        for (int k = 0; k < FB; k++) begin
            for (int c = 0; c < BIT_CYCLES; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clock_10KHZ);
                if (c == 0) begin
                    bits[k] = tx_out;
                    if (k == drop_pos) enable = 1'b0;
                end else if (tx_out !== bits[k]) begin
                    stable = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        len_in = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_10KHZ);
            total++;
            if ({tx_out, dequeue_out, busy_out, sent_count_out} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
                bad++;
                $display("FAIL reset_hold got tx/deq/busy/cnt=%b/%b/%b/%0d exp 1/0/0/0",
                         tx_out, dequeue_out, busy_out, sent_count_out);
            end
        end
        reset = 1'b1;
        @(negedge clock_10KHZ);
        total++;
        if ({dequeue_out, busy_out} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release_req got deq/busy=%b/%b exp 1/1", dequeue_out, busy_out);
        end
        len_in = 4'd0;
        repeat (60) @(negedge clock_10KHZ);
    endtask

    task automatic test_empty_queue();
        apply_reset();
        enable = 1'b1;
        len_in = 4'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock_10KHZ);
            total++;
            if ({dequeue_out, tx_out, busy_out} !== 3'b010) begin
                bad++;
                $display("FAIL empty_idle cycle %0d got deq/tx/busy=%b/%b/%b exp 0/1/0",
                         i, dequeue_out, tx_out, busy_out);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [FB-1:0] bits;
        logic stable;
        int p0, found;
        apply_reset();
        p0 = deq_pulses;
        q_data_in = 8'h00;
        len_in = 4'd1;
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_10KHZ);
            if (dequeue_out === 1'b1) begin
                found = 1;
                break;
            end
        end
        total++;
        if (found != 1) begin
            bad++;
            $display("FAIL single_pulse got none within 10 cycles exp pulse");
        end
        total++;
        if (busy_out !== 1'b1) begin
            bad++;
            $display("FAIL single_busy_rise got %b exp 1", busy_out);
        end
        len_in = 4'd0;
        // Byte becomes valid only DEQ_LAT cycles after the pulse; earlier sampling would latch 0x00.
        repeat (DEQ_LAT) @(negedge clock_10KHZ);
        q_data_in = 8'hA5;
        @(negedge clock_10KHZ);
        total++;
        if (tx_out !== 1'b0) begin
            bad++;
            $display("FAIL single_start_latency got tx=%b exp 0", tx_out);
        end
        capture_frame(-1, bits, stable);
        q_data_in = 8'h00;
        total++;
        if (bits !== frame_of(8'hA5)) begin
            bad++;
            $display("FAIL single_frame_bits got %b exp %b", bits, frame_of(8'hA5));
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("FAIL single_bit_width got unstable exp %0d cycles per bit", BIT_CYCLES);
        end
        @(negedge clock_10KHZ);
        total++;
        if ({busy_out, tx_out, sent_count_out} !== {1'b0, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL single_end got busy/tx/cnt=%b/%b/%0d exp 0/1/1", busy_out, tx_out, sent_count_out);
        end
        repeat (20) @(negedge clock_10KHZ);
        total++;
        if (deq_pulses - p0 != 1) begin
            bad++;
            $display("FAIL single_pulse_count got %0d exp 1", deq_pulses - p0);
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] data [3] = '{8'h3C, 8'h81, 8'hFF};
        logic [FB-1:0] bits;
        logic stable;
        int p0, w;
        apply_reset();
        p0 = deq_pulses;
        len_in = 4'd3;
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            q_data_in = data[f];
            wait_start(20, w);
            total++;
            if (w != ((f == 0) ? 1 + DEQ_LAT + 1 : 1 + 1 + DEQ_LAT + 1)) begin
                bad++;
                $display("FAIL b2b_gap frame %0d got %0d negedges exp %0d",
                         f, w, (f == 0) ? 1 + DEQ_LAT + 1 : 1 + 1 + DEQ_LAT + 1);
            end
            len_in = len_in - 4'd1;
            capture_frame(-1, bits, stable);
            total++;
            if (bits !== frame_of(data[f]) || stable !== 1'b1) begin
                bad++;
                $display("FAIL b2b_frame %0d got %b stable=%b exp %b stable=1", f, bits, stable, frame_of(data[f]));
            end
        end
        @(negedge clock_10KHZ);
        total++;
        if ({busy_out, sent_count_out} !== {1'b0, 8'd3}) begin
            bad++;
            $display("FAIL b2b_count got busy/cnt=%b/%0d exp 0/3", busy_out, sent_count_out);
        end
        repeat (30) @(negedge clock_10KHZ);
        total++;
        if (deq_pulses - p0 != 3) begin
            bad++;
            $display("FAIL b2b_pulses got %0d exp 3", deq_pulses - p0);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [FB-1:0] bits;
        logic stable;
        int p0, w;
        apply_reset();
        p0 = deq_pulses;
        len_in = 4'd2;
        q_data_in = 8'h5A;
        enable = 1'b1;
        wait_start(20, w);
        total++;
        if (w == -1) begin
            bad++;
            $display("FAIL drop_start got timeout exp start bit");
        end
        capture_frame(3, bits, stable);
        total++;
        if (bits !== frame_of(8'h5A) || stable !== 1'b1) begin
            bad++;
            $display("FAIL drop_frame got %b stable=%b exp %b stable=1", bits, stable, frame_of(8'h5A));
        end
        @(negedge clock_10KHZ);
        total++;
        if ({busy_out, sent_count_out} !== {1'b0, 8'd1}) begin
            bad++;
            $display("FAIL drop_end got busy/cnt=%b/%0d exp 0/1", busy_out, sent_count_out);
        end
        repeat (30) @(negedge clock_10KHZ);
        total++;
        if (deq_pulses - p0 != 1 || busy_out !== 1'b0) begin
            bad++;
            $display("FAIL drop_no_req got pulses=%0d busy=%b exp 1/0", deq_pulses - p0, busy_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [FB-1:0] bits;
        logic stable;
        int p0, w;
        len_in = 4'd1;
        q_data_in = 8'hA5;
        enable = 1'b1;
        wait_start(20, w);
        len_in = 4'd0;
        repeat (BIT_CYCLES * 5) @(negedge clock_10KHZ);
        #10;
        total++;
        if ({tx_out, busy_out} !== 2'b01) begin
            bad++;
            $display("FAIL midrst_bit4 got tx/busy=%b/%b exp 0/1", tx_out, busy_out);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({tx_out, busy_out, dequeue_out, sent_count_out} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL midrst_async got tx/busy/deq/cnt=%b/%b/%b/%0d exp 1/0/0/0",
                     tx_out, busy_out, dequeue_out, sent_count_out);
        end
        repeat (3) @(negedge clock_10KHZ);
        p0 = deq_pulses;
        reset = 1'b1;
        len_in = 4'd1;
        q_data_in = 8'hC3;
        wait_start(20, w);
        total++;
        if (w != 1 + DEQ_LAT + 1) begin
            bad++;
            $display("FAIL midrst_restart got %0d negedges exp %0d", w, 1 + DEQ_LAT + 1);
        end
        len_in = 4'd0;
        capture_frame(-1, bits, stable);
        total++;
        if (bits !== frame_of(8'hC3) || stable !== 1'b1) begin
            bad++;
            $display("FAIL midrst_frame got %b stable=%b exp %b stable=1", bits, stable, frame_of(8'hC3));
        end
        @(negedge clock_10KHZ);
        total++;
        if ({sent_count_out, busy_out} !== {8'd1, 1'b0} || deq_pulses - p0 != 1) begin
            bad++;
            $display("FAIL midrst_count got cnt/busy/pulses=%0d/%b/%0d exp 1/0/1",
                     sent_count_out, busy_out, deq_pulses - p0);
        end
        enable = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_empty_queue();
        test_single_frame();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
